snake_head_ctrl: RTL
====================

// Module: snake_head_ctrl
// PURPOSE
// - Upstream stage of the snake body shift register: computes the next head segment and pulses
//   that register's enable once per game move.
// - Latches player direction, applies grid wrap-around, detects food and self-collision.
// - Tracks snake length; owns the IDLE/LOAD/RUN/OVER game FSM.
// - Segment format {x[COORD_W-1:0], y[COORD_W-1:0]}; body vector head = MSB segment (index 0).
// PARAMETERS
// - COORD_W   4   bits per coordinate; SEG_W = 2*COORD_W (8 at default)
// - MAX_LEN  16   body vector capacity in segments
// - GRID_X   16   columns; legal x = 0..GRID_X-1
// - GRID_Y   12   rows; legal y = 0..GRID_Y-1
// - INIT_LEN  3   length after start (2..MAX_LEN)
// - START_X   8   head x after start
// - START_Y   6   head y after start; START_X >= INIT_LEN-1
// PORTS
// - clk        in   1               system clock (CLOCK_50 at top)
// - resetn     in   1               synchronous, active-low reset
// - start      in   1               1-cycle pulse: begin game (honoured in IDLE/OVER only)
// - tick       in   1               1-cycle move strobe from game timer
// - dir_valid  in   1               dir_req qualifier
// - dir_req    in   2               00 up(y-1), 01 right(x+1), 10 down(y+1), 11 left(x-1)
// - food_xy    in   SEG_W           current food segment
// - body       in   SEG_W*MAX_LEN   shift-register contents (head at MSBs)
// - head_next  out  SEG_W           segment to shift in (feeds data_in)
// - shift_en   out  1               1-cycle enable to body shift register
// - length     out  clog2(MAX_LEN+1) valid segments in body
// - ate        out  1               1-cycle pulse, same cycle as the shift_en that eats food
// - game_over  out  1               level, high in OVER
// BEHAVIOUR
// - Reset (any state, any cycle):
//   - state=IDLE, cur_dir=01, pend_dir=01, length=0, shift_en=0, ate=0, game_over=0.
//   - head_next={START_X,START_Y}.
//   - In-flight move discarded; no shift_en is emitted.
// - IDLE:
//   - start -> LOAD: length=INIT_LEN, cur_dir=pend_dir=01.
// - LOAD:
//   - INIT_LEN consecutive cycles, shift_en=1.
//   - Cycle k (k=0..INIT_LEN-1): head_next={START_X-INIT_LEN+1+k, START_Y}.
//   - After the last cycle -> RUN; tick ignored during LOAD.
// - Direction handling:
//   - dir_valid samples dir_req into pend_dir every cycle in RUN/CALC, except a reversal of
//     cur_dir (up<->down, left<->right), which is dropped.
//   - Last valid request wins.
//   - dir_req sampled in the same cycle as tick applies to that move.
// - RUN:
//   - tick -> CALC; cur_dir <= pend_dir (or dir_req if valid/legal that cycle).
// - CALC (1 cycle): registers nxt = head + step(cur_dir) with wrap:
//   - x=GRID_X-1 right -> 0; x=0 left -> GRID_X-1.
//   - y=0 up -> GRID_Y-1; y=GRID_Y-1 down -> 0.
//   - eat = (nxt == food_xy).
//   - hit = nxt equals body segment i for i < length-1 (tail vacates); i < length if eat.
//   - Next state: COMMIT if !hit, else OVER.
// - COMMIT (1 cycle):
//   - shift_en=1, head_next=nxt, ate=eat.
//   - length <= min(length+eat, MAX_LEN); saturates (tail lost) at MAX_LEN.
//   - -> RUN.
// - Latency: tick to shift_en = exactly 2 cycles; tick in CALC/COMMIT dropped (timer period >= 3).
// - OVER:
//   - game_over=1, shift_en=0; body and length frozen.
//   - start -> LOAD (game_over drops next cycle).
// - Arithmetic:
//   - Coordinates unsigned COORD_W.
//   - Wrap compare against GRID-1 constants (no modulo); grid need not be a power of 2.
// - head_next holds its last value outside LOAD/COMMIT.
// STRUCTURE
// - snake_defs.vh (shared, `include):
//   - DIR_UP/RIGHT/DOWN/LEFT encodings, COORD_W/SEG_W defaults.
//   - State encodings, segment pack/unpack macros.
// - Sub-module snake_body_hit: combinational compare of a segment vs body[0..lim-1]; returns hit.
//   - Reused later by the food placer.
// - FSM, direction latch, wrap adder, length counter live in this module.
// TESTING
// - Reset, start -> 3 shift_en cycles with head_next 6,7,8 @y=6; length=3; RUN; head_next={8,6}.
// - dir_req=11 (reverse) then tick -> ignored, head {9,6}.
//   - Then dir_req=00, tick -> head {9,5}, shift_en 2 cycles after tick.
// - Head {15,6} right, tick -> head_next {0,6}.
//   - Head {3,0} up -> {3,11}.
// - food_xy = next head; tick -> ate=1 with shift_en, length 3->4.
//   - At length 16 with ate -> length stays 16.
// - Body loops so next head equals segment 2 -> no shift_en, game_over=1.
//   - Next head equals tail (no eat) -> legal move.
// - resetn low in the CALC cycle -> no shift_en, IDLE, length=0.
//   - Tick during CALC -> no second move.

Source files
------------

// File: rtl/snake_head_ctrl_pkg.sv
// Shared types for the snake head controller: move directions, game FSM states.
// Helper to spot a direction request that reverses the current heading.
package snake_head_ctrl_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_CALC,
        ST_COMMIT,
        ST_OVER
    } state_t;

    // Opposite directions differ only in the MSB of the encoding.
    function automatic logic is_reverse(input dir_t a, input dir_t b);
        return (a ^ b) == 2'b10;
    endfunction

endpackage

// File: rtl/snake_body_hit.sv
// Combinational compare of one segment against body segments 0..lim-1 (segment 0 at MSBs).
// Zero latency, no flow control.
module snake_body_hit #(
    parameter int SEG_W   = 8,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic [SEG_W-1:0]         seg,
    input  logic [SEG_W*MAX_LEN-1:0] body,
    input  logic [LEN_W-1:0]         lim,
    output logic                     hit
);

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < lim) && (body[SEG_W*(MAX_LEN-i)-1 -: SEG_W] == seg)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_head_ctrl.sv
// Snake head controller: next-head computation with wrap, food/self-hit detection, game FSM.
// tick to shift_en is 2 cycles; ticks arriving outside RUN are dropped, no other backpressure.
module snake_head_ctrl
    import snake_head_ctrl_pkg::*;
#(
    parameter int COORD_W  = 4,
    parameter int MAX_LEN  = 16,
    parameter int GRID_X   = 16,
    parameter int GRID_Y   = 12,
    parameter int INIT_LEN = 3,
    parameter int START_X  = 8,
    parameter int START_Y  = 6,
    localparam int SEG_W   = 2 * COORD_W,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic                     tick,
    input  logic                     dir_valid,
    input  logic [1:0]               dir_req,
    input  logic [SEG_W-1:0]         food_xy,
    input  logic [SEG_W*MAX_LEN-1:0] body,
    output logic [SEG_W-1:0]         head_next,
    output logic                     shift_en,
    output logic [LEN_W-1:0]         length,
    output logic                     ate,
    output logic                     game_over
);

    localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(GRID_X - 1);
    localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(GRID_Y - 1);
    localparam logic [COORD_W-1:0] X_LOAD = COORD_W'(START_X - INIT_LEN + 1);

    state_t             state, state_nxt;
    dir_t               cur_dir, pend_dir;
    logic [LEN_W-1:0]   load_cnt;
    logic [COORD_W-1:0] hx, hy, nx, ny;
    logic [SEG_W-1:0]   nxt;
    logic [LEN_W-1:0]   lim;
    logic               eat, hit, req_ok;

    assign {hx, hy} = body[SEG_W*MAX_LEN-1 -: SEG_W];
    assign req_ok   = dir_valid && !is_reverse(dir_t'(dir_req), cur_dir);

    always_comb begin
        nx = hx;
        ny = hy;
        case (cur_dir)
            DIR_UP:    ny = (hy == '0)    ? Y_MAX : hy - COORD_W'(1);
            DIR_RIGHT: nx = (hx == X_MAX) ? '0    : hx + COORD_W'(1);
            DIR_DOWN:  ny = (hy == Y_MAX) ? '0    : hy + COORD_W'(1);
            DIR_LEFT:  nx = (hx == '0)    ? X_MAX : hx - COORD_W'(1);
            default:   nx = hx;
        endcase
    end

    assign nxt = {nx, ny};
    assign eat = (nxt == food_xy);
    // The tail moves out of the way on a normal move, but stays put when we grow.
    assign lim = eat ? length : length - LEN_W'(1);

    snake_body_hit #(
        .SEG_W   (SEG_W),
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_hit (
        .seg  (nxt),
        .body (body),
        .lim  (lim),
        .hit  (hit)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_LOAD;
            ST_LOAD:   if (load_cnt == LEN_W'(INIT_LEN - 1)) state_nxt = ST_RUN;
            ST_RUN:    if (tick) state_nxt = ST_CALC;
            ST_CALC:   state_nxt = hit ? ST_OVER : ST_COMMIT;
            ST_COMMIT: state_nxt = ST_RUN;
            ST_OVER:   if (start) state_nxt = ST_LOAD;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so a reset edge always kills them.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            cur_dir   <= DIR_RIGHT;
            pend_dir  <= DIR_RIGHT;
            length    <= '0;
            load_cnt  <= '0;
            head_next <= {COORD_W'(START_X), COORD_W'(START_Y)};
            shift_en  <= 1'b0;
            ate       <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_en  <= (state_nxt == ST_LOAD) || (state_nxt == ST_COMMIT);
            ate       <= (state_nxt == ST_COMMIT) && eat;
            game_over <= (state_nxt == ST_OVER);

            if (state_nxt == ST_LOAD) begin
                if (state == ST_LOAD) begin
                    load_cnt  <= load_cnt + LEN_W'(1);
                    head_next <= {head_next[SEG_W-1 -: COORD_W] + COORD_W'(1), COORD_W'(START_Y)};
                end else begin
                    load_cnt  <= '0;
                    length    <= LEN_W'(INIT_LEN);
                    cur_dir   <= DIR_RIGHT;
                    pend_dir  <= DIR_RIGHT;
                    head_next <= {X_LOAD, COORD_W'(START_Y)};
                end
            end

            if ((state == ST_CALC) && !hit) begin
                head_next <= nxt;
            end

            if ((state == ST_COMMIT) && ate && (length != LEN_W'(MAX_LEN))) begin
                length <= length + LEN_W'(1);
            end

            if (((state == ST_RUN) || (state == ST_CALC)) && req_ok) begin
                pend_dir <= dir_t'(dir_req);
            end

            if ((state == ST_RUN) && tick) begin
                cur_dir <= req_ok ? dir_t'(dir_req) : pend_dir;
            end
        end
    end

endmodule
